// File: rtl/cvxif_vrf_sched_pkg.sv
// Shared types and geometry for the CV-X-IF vector register file scheduler.
// A VRF word address is {vreg index, word-within-vreg}.
package cvxif_vrf_sched_pkg;

  localparam int unsigned NumVregs     = 32;
  localparam int unsigned WordsPerReg  = 16;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned NumReadPorts = 2;
  localparam int unsigned VregWidth    = $clog2(NumVregs);
  localparam int unsigned WordWidth    = $clog2(WordsPerReg);
  localparam int unsigned AddrWidth    = $clog2(NumVregs * WordsPerReg);
  localparam int unsigned VlenWidth    = $clog2(WordsPerReg) + 1;

  typedef logic [VregWidth-1:0] vreg_idx_t;
  typedef logic [WordWidth-1:0] word_idx_t;
  typedef logic [AddrWidth-1:0] vec_addr_t;
  typedef logic [VlenWidth-1:0] vlen_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } sched_state_e;

  function automatic vec_addr_t word_addr(vreg_idx_t vreg, word_idx_t word);
    return {vreg, word};
  endfunction

endpackage

// File: rtl/vrf_hazard_check.sv
// Combinational issue gate: blocks an instruction on RAW/WAW/WAR hazards
// against the in-flight calc op, and blocks a second calc while one is active.
module vrf_hazard_check
  import cvxif_vrf_sched_pkg::*;
(
  input  logic                              active,
  input  logic                              wr_pend,
  input  logic [VregWidth-1:0]              vd_q,
  input  logic [NumReadPorts-1:0]           rd_pend,
  input  logic [NumReadPorts*VregWidth-1:0] vs_q,
  input  logic                              issue_calc,
  input  logic [VregWidth-1:0]              issue_vd,
  input  logic                              issue_vd_en,
  input  logic [NumReadPorts*VregWidth-1:0] issue_vs,
  input  logic [NumReadPorts-1:0]           issue_vs_en,
  output logic                              ready
);

  logic raw, war, waw;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    raw = 1'b0;
    war = 1'b0;
    for (int i = 0; i < NumReadPorts; i++) begin
      raw = raw | (issue_vs_en[i] && wr_pend &&
                   (issue_vs[i*VregWidth +: VregWidth] == vd_q));
      war = war | (issue_vd_en && rd_pend[i] &&
                   (vs_q[i*VregWidth +: VregWidth] == issue_vd));
    end
  end

  assign waw   = issue_vd_en && wr_pend && (issue_vd == vd_q);
  assign ready = !(issue_calc && active) && !raw && !waw && !war;

endmodule

// File: rtl/cvxif_vrf_sched.sv
// VRF issue scheduler and single write-port arbiter (moves beat calc stream).
// Optional CVXIF_VRF_SCHED_PERF_EN adds saturating stall/conflict counters.
module cvxif_vrf_sched
  import cvxif_vrf_sched_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic                              issue_calc_i,
  input  logic [VregWidth-1:0]              issue_vd_i,
  input  logic                              issue_vd_en_i,
  input  logic [NumReadPorts*VregWidth-1:0] issue_vs_i,
  input  logic [NumReadPorts-1:0]           issue_vs_en_i,
  input  logic [VlenWidth-1:0]              issue_vlen_i,
  input  logic [NumReadPorts-1:0]           rd_done_i,
  input  logic                              mv_wvalid_i,
  input  logic [AddrWidth-1:0]              mv_waddr_i,
  input  logic [DataWidth-1:0]              mv_wdata_i,
  input  logic                              st_wvalid_i,
  output logic                              st_wready_o,
  input  logic [DataWidth-1:0]              st_wdata_i,
  output logic                              vrf_we_o,
  output logic [AddrWidth-1:0]              vrf_waddr_o,
  output logic [DataWidth-1:0]              vrf_wdata_o,
  output logic                              calc_busy_o
`ifdef CVXIF_VRF_SCHED_PERF_EN
  ,
  output logic [31:0]                       stall_cnt_o,
  output logic [31:0]                       arb_conflict_cnt_o
`endif
);

  sched_state_e                      state_q, state_d;
  vreg_idx_t                         vd_q;
  logic [NumReadPorts*VregWidth-1:0] vs_q;
  logic [NumReadPorts-1:0]           rd_pend_q, rd_pend_d;
  logic                              wr_pend_q, wr_pend_d;
  vlen_t                             wcnt_q, wcnt_d;
  vec_addr_t                         waddr_q, waddr_d;
  logic                              calc_accept, st_accept, all_clear;

  vrf_hazard_check u_hazard (
    .active      (state_q == ACTIVE),
    .wr_pend     (wr_pend_q),
    .vd_q        (vd_q),
    .rd_pend     (rd_pend_q),
    .vs_q        (vs_q),
    .issue_calc  (issue_calc_i),
    .issue_vd    (issue_vd_i),
    .issue_vd_en (issue_vd_en_i),
    .issue_vs    (issue_vs_i),
    .issue_vs_en (issue_vs_en_i),
    .ready       (issue_ready_o)
  );

  assign calc_accept = issue_valid_i && issue_ready_o && issue_calc_i;
  assign st_wready_o = wr_pend_q && !mv_wvalid_i;
  assign st_accept   = st_wvalid_i && st_wready_o;
  assign all_clear   = !wr_pend_q && (rd_pend_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Returning to IDLE looks at the registered pending bits, so a new calc
  // is accepted one cycle after the last completion has been recorded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (calc_accept && (issue_vlen_i != '0 || issue_vs_en_i != '0)) state_d = ACTIVE;
      ACTIVE:  if (all_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    calc_busy_o = (state_q == ACTIVE);
    vrf_we_o    = mv_wvalid_i || st_accept;
    vrf_waddr_o = waddr_q;
    vrf_wdata_o = st_wdata_i;
    if (mv_wvalid_i) begin
      vrf_waddr_o = mv_waddr_i;
      vrf_wdata_o = mv_wdata_i;
    end
  end

  // Only the word index advances, so the stream cannot leave its vreg.
  always_comb begin
    rd_pend_d = rd_pend_q & ~rd_done_i;
    wr_pend_d = wr_pend_q;
    wcnt_d    = wcnt_q;
    waddr_d   = waddr_q;
    if (st_accept) begin
      wcnt_d  = wcnt_q - vlen_t'(1);
      waddr_d = word_addr(waddr_q[AddrWidth-1 -: VregWidth],
                          word_idx_t'(waddr_q[WordWidth-1:0] + word_idx_t'(1)));
      if (wcnt_q == vlen_t'(1)) wr_pend_d = 1'b0;
    end
    if (calc_accept) begin
      rd_pend_d = issue_vs_en_i;
      wr_pend_d = issue_vd_en_i && (issue_vlen_i != '0);
      wcnt_d    = (issue_vlen_i > vlen_t'(WordsPerReg)) ? vlen_t'(WordsPerReg) : issue_vlen_i;
      waddr_d   = word_addr(issue_vd_i, '0);
    end
  end

  // NOTE: operand latches are reset as well; they only matter under a pending bit, but a defined value keeps X out of the hazard compares.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q <= '0;
      wr_pend_q <= 1'b0;
      wcnt_q    <= '0;
      waddr_q   <= '0;
      vd_q      <= '0;
      vs_q      <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      wcnt_q    <= wcnt_d;
      waddr_q   <= waddr_d;
      if (calc_accept) begin
        vd_q <= issue_vd_i;
        vs_q <= issue_vs_i;
      end
    end
  end

`ifdef CVXIF_VRF_SCHED_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o        <= '0;
      arb_conflict_cnt_o <= '0;
    end else begin
      if (issue_valid_i && !issue_ready_o && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (mv_wvalid_i && st_wvalid_i && wr_pend_q && arb_conflict_cnt_o != '1)
        arb_conflict_cnt_o <= arb_conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cvxif_vrf_sched.md
Name: cvxif_vrf_sched

Overview:
- Issue-side scheduler and write-port arbiter for the custom vector register file (VRF) in the CV-X-IF coprocessor.
- Tracks in-flight vector calc ops and decides per instruction whether issue may proceed; blocks on RAW, WAW or WAR hazards on vector registers.
- Generates the stream write address for the calc unit's result stream.
- Arbitrates the single VRF write port between scalar moves (MV_X_V) and the calc result stream.

Parameters:
NumVregs, 32, number of vector registers
WordsPerReg, 16, XLEN words per vector register
DataWidth, 64, word width (XLEN)
NumReadPorts, 2, VRF read ports / calc source operands
AddrWidth, $clog2(NumVregs*WordsPerReg) = 9, VRF word address width
VlenWidth, $clog2(WordsPerReg)+1 = 5, vector length width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  instruction offered (already decoded)
issue_ready_o  out  1  instruction may be accepted this cycle
issue_calc_i  in  1  1 = vector calc op, 0 = move op
issue_vd_i  in  5  destination vreg
issue_vd_en_i  in  1  op writes a vreg
issue_vs_i  in  NumReadPorts*5  source vregs
issue_vs_en_i  in  NumReadPorts  source vreg used, per port
issue_vlen_i  in  VlenWidth  calc vector length in words
rd_done_i  in  NumReadPorts  pulse: read stream on port i finished
mv_wvalid_i  in  1  move write request (MV_X_V)
mv_waddr_i  in  AddrWidth  move write word address
mv_wdata_i  in  DataWidth  move write data
st_wvalid_i  in  1  calc result word valid
st_wready_o  out  1  calc result word accepted
st_wdata_i  in  DataWidth  calc result data
vrf_we_o  out  1  VRF write enable
vrf_waddr_o  out  AddrWidth  VRF write address
vrf_wdata_o  out  DataWidth  VRF write data
calc_busy_o  out  1  calc op in flight

Behaviour:
- Reset: state IDLE; all pending bits 0; word counter 0; calc_busy_o=0; vrf_we_o=0; st_wready_o=0 (no stream accepted while IDLE).
- FSM IDLE/ACTIVE.
  - IDLE->ACTIVE on accepted calc op with vlen!=0 or any source enabled.
  - ACTIVE->IDLE in the cycle all pending bits clear (registered). Next calc is accepted no earlier than the following cycle.
  - calc_busy_o = (state==ACTIVE).
- Calc op acceptance:
  - Latch vd and vs[i].
  - rd_pend_q[i] = vs_en[i].
  - wr_pend_q = vd_en && vlen!=0.
  - Word counter = min(vlen, WordsPerReg).
  - Stream address = {vd, zeros}.
- Busy vregs (combinational from latched state):
  - wbusy(v) = wr_pend_q && vd_q==v.
  - rbusy(v) = OR over i of (rd_pend_q[i] && vs_q[i]==v).
- issue_ready_o is combinational and independent of issue_valid_i. It is 0 if any of:
  - issue_calc_i && ACTIVE;
  - any enabled source with wbusy (RAW);
  - vd_en && wbusy(vd) (WAW);
  - vd_en && rbusy(vd) (WAR).
- Accept = issue_valid_i && issue_ready_o. Move ops never change scheduler state.
- rd_done_i[i] clears rd_pend_q[i]. A pulse with rd_pend_q[i]=0 is ignored.
- Stream write:
  - Accepted when st_wvalid_i && st_wready_o.
  - Write address = stream address; then address+1, counter-1.
  - Counter reaching 0 clears wr_pend_q. Addresses never cross the vreg boundary.
- Write arbitration: move has fixed priority, since it was already accepted at issue.
  - st_wready_o = wr_pend_q && !mv_wvalid_i.
  - vrf_* driven from move if mv_wvalid_i, else from accepted stream word; vrf_we_o = mv_wvalid_i || stream accept.
  - Output is combinational, zero latency.
- Simultaneous events: the last stream word and the last rd_done in the same cycle -> IDLE next cycle.
- Reset mid-op: all in-flight tracking is dropped immediately.

Optional Feature:
- Macro CVXIF_VRF_SCHED_PERF_EN.
- When defined, adds outputs:
  - stall_cnt_o[31:0]: counts cycles with issue_valid_i && !issue_ready_o.
  - arb_conflict_cnt_o[31:0]: counts cycles with mv_wvalid_i && st_wvalid_i && wr_pend_q.
  - Both saturate at all-ones and reset to 0.
- When undefined, neither port nor counter exists.

Decomposition:
- Package cvxif_vrf_sched_pkg holds:
  - vreg_idx_t (5 bits), vec_addr_t, vlen_t;
  - sched_state_e {IDLE, ACTIVE};
  - function word_addr(vreg, word).
- One sub-module is natural: vrf_hazard_check, purely combinational. It takes the latched pending state plus the issue fields and returns the ready decision.

Test Plan:
1. Calc vd=3, vs=1,2, vlen=16 accepted; stream 16 words -> vrf_waddr_o 48..63. IDLE after rd_done both ports plus the last word; 17th st_wvalid_i gets st_wready_o=0.
2. During that calc, move MV_V_X reading v3 -> issue_ready_o=0 (RAW). Move MV_X_V to v1 -> 0 (WAR). Move to v5 -> 1.
3. mv_wvalid_i and st_wvalid_i in the same cycle (addr 80, data A) -> vrf_waddr_o=80, data A, st_wready_o=0. Stream word written the next cycle at the unchanged address.
4. Second calc offered while ACTIVE -> held off; last rd_done and last word in the same cycle -> accepted exactly 2 cycles later.
5. Calc vd=0, vs=0,0, vlen=0 -> wr_pend 0. rd_done_i=2'b01 leaves v0 rbusy; after 2'b10, MV_X_V to v0 ready.
6. rst_ni low mid-stream (counter=7) -> calc_busy_o=0, st_wready_o=0, issue_ready_o=1 for any op after release. With PERF_EN: stall_cnt_o counts scenario 2 stalls exactly.
